// File: rtl/countdown_64_pkg.sv
`default_nettype none
// ============================================================================
// Module   : countdown_64_pkg
// Purpose  : Shared constants for the 6-bit iteration down-counter. The FSM
//            state encodings match the multdiv control FSM so the two can be
//            decoded with the same constants.
// Contents : c_width, c_st_idle / c_st_run / c_st_done, state_t
// Revision : 1.0 - initial release
// ============================================================================
package countdown_64_pkg;

  localparam int c_width = 6;

  typedef logic [1:0] state_t;

  localparam state_t c_st_idle = 2'b00;
  localparam state_t c_st_run  = 2'b01;
  localparam state_t c_st_done = 2'b10;

endpackage : countdown_64_pkg
`default_nettype wire

// File: rtl/countdown_64_tff_ld.sv
`default_nettype none
// ============================================================================
// Module   : tff_ld
// Purpose  : Loadable toggle flip-flop, one bit of the ripple-borrow counter.
//            Load takes priority over toggle.
// Ports    : clk   - rising-edge clock
//            clr_n - asynchronous active-low clear
//            ld    - load d into q
//            d     - load value
//            t     - toggle enable
//            q     - stored bit
// Revision : 1.0 - initial release
// ============================================================================
module tff_ld (
  input  logic clk,
  input  logic clr_n,
  input  logic ld,
  input  logic d,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q <= 1'b0;
    end else if (ld) begin
      r_q <= d;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule : tff_ld
`default_nettype wire

// File: rtl/countdown_64.sv
`default_nettype none
// ============================================================================
// Module   : countdown_64
// Purpose  : Loadable 6-bit down-counter with start/ready/done handshake.
//            Counts a programmed number of iterations down to zero and pulses
//            done for one cycle. Datapath is a ripple-borrow chain of toggle
//            flip-flops.
// Ports    : clk      - rising-edge clock
//            clr_n    - asynchronous active-low clear
//            start    - load count_in and begin (accepted only when ready)
//            count_in - iteration count N (0..63)
//            stall    - hold the count this cycle while running
//            out      - remaining count
//            ready    - idle, can accept start
//            busy     - counting
//            done     - one-cycle completion pulse, out==0 while high
// Revision : 1.0 - initial release
// ============================================================================
module countdown_64
  import countdown_64_pkg::*;
(
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic [c_width-1:0] count_in,
  input  logic               stall,
  output logic [c_width-1:0] out,
  output logic               ready,
  output logic               busy,
  output logic               done
);

  state_t             r_state;
  state_t             w_next_state;
  logic [c_width-1:0] w_q;
  logic [c_width-1:0] w_t;
  logic               w_ld;
  logic               w_dec;
  logic               w_out_is_one;

  // --------------------------------------------------------------------------
  // Datapath control
  // --------------------------------------------------------------------------
  // A load happens only from IDLE; a zero count loads 0 and heads to DONE.
  assign w_ld  = (r_state == c_st_idle) && start;

  // The nonzero guard keeps the borrow chain from ever wrapping 0 -> 63,
  // even though RUN is never entered with a zero count.
  assign w_dec = (r_state == c_st_run) && !stall && (|w_q);

  assign w_out_is_one = (w_q == c_width'(1));

  // Borrow chain: bit i toggles when all lower bits are zero.
  assign w_t[0] = w_dec;

  generate
    for (genvar i = 1; i < c_width; i++) begin : g_borrow
      assign w_t[i] = w_t[i-1] & ~w_q[i-1];
    end
  endgenerate

  generate
    for (genvar i = 0; i < c_width; i++) begin : g_bits
      tff_ld u_tff (
        .clk   (clk),
        .clr_n (clr_n),
        .ld    (w_ld),
        .d     (count_in[i]),
        .t     (w_t[i]),
        .q     (w_q[i])
      );
    end
  endgenerate

  assign out = w_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (start) begin
          w_next_state = (count_in == '0) ? c_st_done : c_st_run;
        end
      end
      c_st_run: begin
        if (!stall && w_out_is_one) begin
          w_next_state = c_st_done;
        end
      end
      c_st_done: begin
        w_next_state = c_st_idle;
      end
      default: begin
        w_next_state = c_st_idle;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode (from registered state only)
  // --------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (r_state)
      c_st_idle: ready = 1'b1;
      c_st_run:  busy  = 1'b1;
      c_st_done: done  = 1'b1;
      default:   ready = 1'b0;
    endcase
  end

endmodule : countdown_64
`default_nettype wire

// File: tb/tb_countdown_64.sv
`default_nettype none
// ============================================================================
// Module   : tb_countdown_64
// Purpose  : Self-checking bench for countdown_64. A behavioural model tracks
//            remaining count and phase; a compare process checks every cycle
//            and directed tests pin exact values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_countdown_64;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic [5:0] count_in;
  logic       stall;
  logic [5:0] out;
  logic       ready;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  countdown_64 dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .count_in (count_in),
    .stall    (stall),
    .out      (out),
    .ready    (ready),
    .busy     (busy),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // --------------------------------------------------------------------------
  // Behavioural model: remaining count plus "counting" / "finished" flags.
  // --------------------------------------------------------------------------
  int m_out      = 0;
  bit m_counting = 0;
  bit m_finished = 0;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_out      = 0;
      m_counting = 0;
      m_finished = 0;
    end else if (m_finished) begin
      m_finished = 0;
    end else if (m_counting) begin
      if (!stall) m_out = m_out - 1;
      if (m_out == 0) begin
        m_counting = 0;
        m_finished = 1;
      end
    end else if (start) begin
      m_out = int'(count_in);
      if (m_out == 0) m_finished = 1;
      else            m_counting = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_out",   int'(out),   m_out);
      chk("model_ready", int'(ready), int'(!m_counting && !m_finished));
      chk("model_busy",  int'(busy),  int'(m_counting));
      chk("model_done",  int'(done),  int'(m_finished));
    end
  end

  int done_pulses = 0;
  always @(negedge clk) if (done) done_pulses++;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int n);
    start    = 1'b1;
    count_in = 6'(n);
    step(1);
    start    = 1'b0;
  endtask

  int  base;
  bit  saw63;

  initial begin
    clr_n    = 1'b0;
    start    = 1'b0;
    count_in = '0;
    stall    = 1'b0;
    step(2);
    chk("reset_out",   int'(out),   0);
    chk("reset_ready", int'(ready), 1);
    chk("reset_busy",  int'(busy),  0);
    chk("reset_done",  int'(done),  0);
    clr_n  = 1'b1;
    cmp_en = 1;
    step(1);

    // Basic count of 5
    go(5);
    chk("basic_load", int'(out), 5);
    chk("model_pin_load", m_out, 5);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      chk("basic_seq", int'(out), 5 - k);
      chk("basic_nodone", int'(done), 0);
    end
    step(1);
    chk("basic_done", int'(done), 1);
    chk("basic_done_out", int'(out), 0);
    step(1);
    chk("basic_ready", int'(ready), 1);
    chk("basic_done_clr", int'(done), 0);

    // Zero count
    go(0);
    chk("zero_done", int'(done), 1);
    chk("zero_out", int'(out), 0);
    chk("zero_busy", int'(busy), 0);
    step(1);
    chk("zero_ready", int'(ready), 1);

    // Reset mid-run: load 10, run 4 cycles, clear between edges
    go(10);
    step(4);
    chk("abort_pre_out", int'(out), 6);
    base = done_pulses;
    #3;
    clr_n = 1'b0;
    #1;
    chk("abort_out",   int'(out),   0);
    chk("abort_ready", int'(ready), 1);
    chk("abort_busy",  int'(busy),  0);
    #1;
    clr_n = 1'b1;
    step(14);
    chk("abort_no_done", done_pulses - base, 0);

    // Full range 63
    go(63);
    chk("full_load", int'(out), 63);
    saw63 = 0;
    for (int k = 1; k <= 62; k++) begin
      step(1);
      if (out == 6'd63) saw63 = 1;
      if (k == 31) chk("full_32", int'(out), 32);
      if (k == 32) chk("full_31", int'(out), 31);
      if (k == 62) chk("full_1", int'(out), 1);
    end
    step(1);
    chk("full_done", int'(done), 1);
    chk("full_zero", int'(out), 0);
    step(1);
    if (out == 6'd63) saw63 = 1;
    chk("full_no_wrap", int'(saw63), 0);
    chk("full_ready", int'(ready), 1);

    // Stall: count 4, stall 3 cycles at out=2, done at cycle 7
    go(4);
    step(2);
    chk("stall_at2", int'(out), 2);
    stall = 1'b1;
    step(3);
    chk("stall_hold", int'(out), 2);
    chk("stall_busy", int'(busy), 1);
    stall = 1'b0;
    step(1);
    chk("stall_1", int'(out), 1);
    step(1);
    chk("stall_done", int'(done), 1);
    step(1);

    // Ignored start during RUN and DONE of a count-3 run
    go(3);
    start    = 1'b1;
    count_in = 6'd9;
    step(1);
    chk("ign_2", int'(out), 2);
    step(1);
    chk("ign_1", int'(out), 1);
    step(1);
    chk("ign_done", int'(done), 1);
    chk("ign_done_out", int'(out), 0);
    step(1);
    chk("ign_ready", int'(ready), 1);
    chk("ign_out0", int'(out), 0);
    step(1);
    start = 1'b0;
    chk("ign_accept", int'(out), 9);
    chk("ign_busy", int'(busy), 1);
    step(11);
    chk("ign_final_ready", int'(ready), 1);

    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_countdown_64
`default_nettype wire
